ivl_mbx_get_eng: RTL and testbench
==================================

IVL_MBX_GET_ENG -- requirements
Module: ivl_mbx_get_eng

Interface
REQ-001 SHALL have parameter DW, default 32: mailbox item width.
REQ-002 SHALL have parameter TMO_W, default 16: timeout counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  get-side request present.
REQ-006 SHALL have port req_ready  output  1  engine accepts request.
REQ-007 SHALL have port req_op  input  2  0=get (blocking), 1=try_get, 2=peek, 3=reserved.
REQ-008 SHALL have port tmo_cyc  input  TMO_W  blocking-get timeout in cycles; 0 = wait forever.
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have port rsp_data  output  DW  item returned; 0 unless status OK.
REQ-012 SHALL have port rsp_status  output  2  0=OK, 1=EMPTY, 2=TIMEOUT, 3=BADOP.
REQ-013 SHALL have port mb_empty  input  1  mailbox holds no item.
REQ-014 SHALL have port mb_rdata  input  DW  mailbox head item (first-word-fall-through, valid while !mb_empty).
REQ-015 SHALL have port mb_pop  output  1  remove head item this cycle.
REQ-016 SHALL have port get_cnt  output  16  count of successful get/try_get pops, wraps at 2^16.

Function
REQ-017 SHALL implement states IDLE, EXEC, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 SHALL accept a request on req_valid&&req_ready, latching req_op and tmo_cyc; IDLE->EXEC, except op 3 -> RESP with BADOP.
REQ-019 In EXEC with !mb_empty, SHALL capture mb_rdata, status OK, go RESP; mb_pop=1 that cycle for get/try_get, 0 for peek.
REQ-020 In EXEC with mb_empty: try_get and peek SHALL go RESP with EMPTY; get SHALL go WAIT and clear the timeout counter.
REQ-021 In WAIT, SHALL poll mb_empty each cycle; on !mb_empty SHALL capture, pop, status OK, go RESP.
REQ-022 In WAIT with latched tmo_cyc!=0, SHALL go RESP with TIMEOUT when the counter reaches tmo_cyc empty cycles (counter counts WAIT cycles, TMO_W bits, no wrap).
REQ-023 If item arrival and timeout coincide in one WAIT cycle, item SHALL win (OK, popped).
REQ-024 Latency: get on non-empty mailbox accepted at cycle N -> mb_pop at N+1 -> rsp_valid at N+2.
REQ-025 mb_pop SHALL be a single-cycle pulse per successful get/try_get and never asserted while mb_empty=1.
REQ-026 In RESP, rsp_valid=1 with rsp_data/rsp_status stable until rsp_ready; on rsp_valid&&rsp_ready SHALL return IDLE (next request accepted next cycle earliest).
REQ-027 get_cnt SHALL increment by 1 in the mb_pop cycle; peeks, failures, timeouts SHALL not count.
REQ-028 mailbox inputs SHALL be ignored in IDLE and RESP.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, rsp_valid=0, rsp_data=0, rsp_status=0, mb_pop=0, get_cnt=0, timeout counter=0.
REQ-030 Reset mid-transaction SHALL abandon it without response; an item popped before reset is lost, no further pop issued.
REQ-031 req_ready SHALL be 0 in any cycle with rst=1.

Configuration
REQ-032 Macro IVL_MBX_PEEK_EN defined: op 2 SHALL behave per REQ-019/020.
REQ-033 Macro IVL_MBX_PEEK_EN undefined: op 2 SHALL be treated as op 3 (BADOP, no mailbox access).

Verification
REQ-034 Mailbox holds 0x12153524; get, rsp_ready=1 -> one mb_pop, rsp_valid at N+2, data 0x12153524, OK, get_cnt=1.
REQ-035 Mailbox empty; try_get -> no mb_pop, rsp EMPTY, data 0, get_cnt unchanged.
REQ-036 Mailbox empty, get with tmo_cyc=0; item 0xC0895E81 arrives 20 cycles later -> pop in arrival cycle, rsp OK 0xC0895E81.
REQ-037 Mailbox empty, get tmo_cyc=5, no item -> TIMEOUT after 5 WAIT cycles; repeat with item arriving in 5th cycle -> OK.
REQ-038 With IVL_MBX_PEEK_EN: peek head 0xDEADBEEF twice -> both OK 0xDEADBEEF, no mb_pop; without macro -> BADOP.
REQ-039 rst asserted in WAIT and in RESP with rsp_ready=0 -> next cycle IDLE, rsp_valid=0, get_cnt=0, no response delivered.

Source files
------------

// File: rtl/ivl_mbx_get_eng.sv
// Mailbox get engine: blocking get with timeout, try_get and optional peek.
// Define IVL_MBX_PEEK_EN to enable op 2 (peek); otherwise op 2 returns BADOP.
`timescale 1ns/1ps
module ivl_mbx_get_eng #(
  parameter int unsigned DW    = 32,
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [TMO_W-1:0] tmo_cyc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic [1:0]       rsp_status,
  input  logic             mb_empty,
  input  logic [DW-1:0]    mb_rdata,
  output logic             mb_pop,
  output logic [15:0]      get_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_GET = 2'd0, OP_TRY = 2'd1, OP_PEEK = 2'd2, OP_RSVD = 2'd3} op_t;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_EMPTY = 2'd1, ST_TIMEOUT = 2'd2, ST_BADOP = 2'd3} status_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    data_q, data_d;
  status_t          status_q, status_d;
  logic [15:0]      get_cnt_q, get_cnt_d;
  logic             pop;
  logic             op_bad;
  logic             is_pop_op;

  always_comb begin
`ifdef IVL_MBX_PEEK_EN
    op_bad = (req_op == 2'd3);
`else
    op_bad = req_op[1];
`endif
  end

  assign is_pop_op = (op_q == OP_GET) || (op_q == OP_TRY);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    status_d  = status_q;
    get_cnt_d = get_cnt_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d  = op_t'(req_op);
          tmo_d = tmo_cyc;
          if (op_bad) begin
            data_d   = '0;
            status_d = ST_BADOP;
            state_d  = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!mb_empty) begin
          data_d   = mb_rdata;
          status_d = ST_OK;
          pop      = is_pop_op;
          state_d  = S_RESP;
        end else if (op_q == OP_GET) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          data_d   = '0;
          status_d = ST_EMPTY;
          state_d  = S_RESP;
        end
      end
      S_WAIT: begin
        // An item present in the same cycle the timeout expires takes priority.
        if (!mb_empty) begin
          data_d   = mb_rdata;
          status_d = ST_OK;
          pop      = 1'b1;
          state_d  = S_RESP;
        end else if ((tmo_q != '0) && (cnt_q == tmo_q - TMO_W'(1))) begin
          data_d   = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) get_cnt_d = get_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_GET;
      tmo_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      status_q  <= ST_OK;
      get_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      status_q  <= status_d;
      get_cnt_q <= get_cnt_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_data   = data_q;
  assign rsp_status = status_q;
  assign mb_pop     = pop && !rst;
  assign get_cnt    = get_cnt_q;

endmodule

// File: tb/tb_ivl_mbx_get_eng.sv
// Scoreboard bench for ivl_mbx_get_eng: mailbox modelled as a queue, responses
// predicted from mailbox contents, op, timeout and item arrival cycle.
`timescale 1ns/1ps
module tb_ivl_mbx_get_eng;
  localparam int DW    = 32;
  localparam int TMO_W = 16;
`ifdef IVL_MBX_PEEK_EN
  localparam bit PEEK = 1'b1;
`else
  localparam bit PEEK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [TMO_W-1:0] tmo_cyc = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [DW-1:0]    rsp_data;
  logic [1:0]       rsp_status;
  logic             mb_empty = 1'b1;
  logic [DW-1:0]    mb_rdata = '0;
  logic             mb_pop;
  logic [15:0]      get_cnt;

  always #5 clk = ~clk;

  ivl_mbx_get_eng #(.DW(DW), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .tmo_cyc(tmo_cyc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .mb_empty(mb_empty),
    .mb_rdata(mb_rdata), .mb_pop(mb_pop), .get_cnt(get_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Mailbox model: driver posts items, this process owns the queue.
  logic [31:0] mbq[$];
  logic [31:0] push_buf[1024];
  int          push_cnt  = 0;
  int          push_done = 0;
  int          pops_seen = 0;
  bit          pend_pop  = 1'b0;

  always @(negedge clk) begin
    if (pend_pop) begin
      if (mbq.size() > 0) void'(mbq.pop_front());
      pend_pop = 1'b0;
    end
    while (push_done < push_cnt) begin
      mbq.push_back(push_buf[push_done]);
      push_done++;
    end
    mb_empty = (mbq.size() == 0);
    mb_rdata = mb_empty ? 32'hBADC0DE5 : mbq[0];
    #1;
    if (mb_pop) begin
      pops_seen++;
      pend_pop = 1'b1;
      check("pop_when_empty", 64'(mb_empty), 64'd0);
    end
  end

  // Scoreboard: expected responses indexed by issue order.
  logic [1:0]  exp_st[1024];
  logic [31:0] exp_d[1024];
  int          issued     = 0;
  int          rsp_cnt    = 0;
  int          ready_mode = 1;

  always @(negedge clk) begin
    case (ready_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'b0;
    endcase
    if (rsp_valid && rsp_ready) begin
      if (rsp_cnt >= issued) begin
        check("rsp_count", 64'(rsp_cnt + 1), 64'(issued));
      end else begin
        check("rsp", 64'({rsp_status, rsp_data}), 64'({exp_st[rsp_cnt], exp_d[rsp_cnt]}));
        rsp_cnt++;
      end
    end
  end

  logic [15:0] exp_cnt   = '0;
  int          pops_exp  = 0;

  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  task automatic post(input logic [31:0] v);
    push_buf[push_cnt] = v;
    push_cnt++;
  endtask

  // k = WAIT cycle in which an item arrives (0 = none arrives).
  task automatic run_txn(input logic [1:0] op, input logic [15:0] tmo, input int k,
                         input logic [31:0] item);
    logic [1:0]  st;
    logic [31:0] d;
    bit          pop_now, pop_any, bad;
    int          lat_exp, lat;
    pop_now = 1'b0;
    pop_any = 1'b0;
    bad     = (op == 2'd3) || (op == 2'd2 && !PEEK);
    if (bad) begin
      st = 2'd3; d = '0; lat_exp = 0;
    end else if (mbq.size() > 0) begin
      st = 2'd0; d = mbq[0]; pop_now = (op < 2'd2); lat_exp = 1;
    end else if (op != 2'd0) begin
      st = 2'd1; d = '0; lat_exp = 1;
    end else if (k > 0 && (tmo == 0 || k <= int'(tmo))) begin
      st = 2'd0; d = item; pop_any = 1'b1; lat_exp = k + 1;
    end else begin
      st = 2'd2; d = '0; lat_exp = int'(tmo) + 1;
    end
    if (pop_now || pop_any) begin
      exp_cnt = exp_cnt + 16'd1;
      pops_exp++;
    end
    exp_st[issued] = st;
    exp_d[issued]  = d;
    issued++;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    tmo_cyc   = tmo;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    tmo_cyc   = 16'($urandom);
    check("mb_pop_exec", 64'(mb_pop), 64'(pop_now));
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (pop_any && c == k) post(item);
    end
    check("latency", 64'(lat), 64'(lat_exp));
    for (int i = 0; i < 300 && rsp_cnt < issued; i++) @(posedge clk);
    check("rsp_delivered", 64'(rsp_cnt), 64'(issued));
    settle();
    check("get_cnt", 64'(get_cnt), 64'(exp_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] tmo;
    int          k;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_get_cnt", 64'(get_cnt), 64'd0);
    check("rst_mb_pop", 64'(mb_pop), 64'd0);
    rst = 1'b0;
    settle();
    check("ready_after_rst", 64'(req_ready), 64'd1);

    ready_mode = 1;
    post(32'h12153524);
    settle();
    run_txn(2'd0, 16'd0, 0, 32'h0);
    run_txn(2'd1, 16'd0, 0, 32'h0);
    run_txn(2'd0, 16'd0, 20, 32'hC0895E81);
    run_txn(2'd0, 16'd5, 0, 32'h0);
    run_txn(2'd0, 16'd5, 5, 32'h5A5A0005);
    run_txn(2'd0, 16'd5, 6, 32'h5A5A0006);
    run_txn(2'd0, 16'd1, 0, 32'h0);
    run_txn(2'd0, 16'd1, 1, 32'h5A5A0001);
    post(32'hDEADBEEF);
    settle();
    run_txn(2'd2, 16'd0, 0, 32'h0);
    run_txn(2'd2, 16'd0, 0, 32'h0);
    run_txn(2'd1, 16'd0, 0, 32'h0);
    run_txn(2'd3, 16'd0, 0, 32'h0);

    // Reset while blocked in WAIT.
    check("req_ready_pre_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = 2'd0; tmo_cyc = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("wait_no_rsp", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("wait_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("wait_rst_get_cnt", 64'(get_cnt), 64'd0);
    check("wait_rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("idle_rst_req_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    exp_cnt = '0;
    settle();
    check("wait_rst_ready", 64'(req_ready), 64'd1);

    // Reset while holding a response the consumer never takes.
    ready_mode = 2;
    post(32'h0BADF00D);
    settle();
    req_valid = 1'b1; req_op = 2'd1; tmo_cyc = '0;
    pops_exp++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("resp_rst_pop", 64'(mb_pop), 64'd1);
    @(posedge clk); #1;
    check("resp_rst_valid_hold", 64'(rsp_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("resp_rst_still_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("resp_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("resp_rst_get_cnt", 64'(get_cnt), 64'd0);
    rst = 1'b0;
    exp_cnt = '0;
    ready_mode = 0;
    repeat (6) @(posedge clk);
    check("resp_rst_no_rsp", 64'(rsp_cnt), 64'(issued));
    settle();

    for (int n = 0; n < 120; n++) begin
      if (mbq.size() < 3 && $urandom_range(0, 1) == 1) begin
        post($urandom);
        settle();
      end
      op  = 2'($urandom_range(0, 3));
      tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      k   = $urandom_range(1, 8);
      run_txn(op, tmo, k, $urandom);
    end

    check("total_pops", 64'(pops_seen), 64'(pops_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
